// File: rtl/otter_hazard_ctrl.sv
// rtl/otter_hazard_ctrl.sv - OTTER load-use stall, redirect flush and operand-forwarding control
// Optional performance counters are built when OTTER_HAZARD_PERF_EN is defined.
module otter_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_rd_wr,
  input  logic              de_is_load,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              if_de_stall,
  output logic              de_ex_bubble,
  output logic              if_de_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_wr;
    logic              is_load;
  } trk_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  trk_t       ex_t, mem_t, wb_t;
  trk_t       ex_next;
  logic [2:0] flush_ctr;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic       rs1_hit_ex, rs2_hit_ex;
  logic       load_use;
  logic       advance;
  logic       unused_wb;

  function automatic logic [1:0] src_sel(input logic used, input logic [REG_AW-1:0] addr,
                                         input trk_t ex, input trk_t mem);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && addr != '0) begin
      if (ex.valid && ex.rd_wr && ex.rd == addr)
        sel = 2'd1;
      else if (mem.valid && mem.rd_wr && mem.rd == addr)
        sel = 2'd2;
    end
    return sel;
  endfunction

  assign rs1_hit_ex = de_rs1_used && (de_rs1 == ex_t.rd);
  assign rs2_hit_ex = de_rs2_used && (de_rs2 == ex_t.rd);
  assign load_use   = de_valid && ex_t.valid && ex_t.is_load && ex_t.rd_wr &&
                      (ex_t.rd != '0) && (rs1_hit_ex || rs2_hit_ex);

  // Redirect overrides the stall: the stalled instruction is on the wrong path anyway.
  assign pc_stall     = RST_N && load_use && !ex_redirect;
  assign if_de_stall  = pc_stall;
  assign de_ex_bubble = RST_N && (load_use || ex_redirect);
  assign if_de_flush  = RST_N && (ex_redirect || flush_ctr != 3'd0);
  assign advance      = de_valid && !load_use && !ex_redirect;

  always_comb begin
    ex_next = '0;
    if (advance) begin
      ex_next.valid   = 1'b1;
      ex_next.rd      = de_rd;
      ex_next.rd_wr   = de_rd_wr;
      ex_next.is_load = de_is_load;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_t      <= '0;
      mem_t     <= '0;
      wb_t      <= '0;
      flush_ctr <= 3'd0;
      fwd_a_q   <= 2'd0;
      fwd_b_q   <= 2'd0;
    end else begin
      ex_t  <= ex_next;
      mem_t <= ex_t;
      wb_t  <= mem_t;
      if (ex_redirect)
        flush_ctr <= FLUSH_RELOAD;
      else if (flush_ctr != 3'd0)
        flush_ctr <= flush_ctr - 3'd1;
      // Bubbles and flushed slots carry no operands, so they never forward.
      fwd_a_q <= advance ? src_sel(de_rs1_used, de_rs1, ex_t, mem_t) : 2'd0;
      fwd_b_q <= advance ? src_sel(de_rs2_used, de_rs2, ex_t, mem_t) : 2'd0;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign unused_wb = ^wb_t;

`ifdef OTTER_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (ex_redirect && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
